// File: rtl/approx_rc_err_monitor_if.sv
// Sample/result stream bundle for approx_rc_err_monitor.
// ERR_BIAS_EN adds the signed bias accumulator output err_bias.
interface approx_rc_err_monitor_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = WIDTH + 1 + CNT_W
);
  logic              clear;
  logic              start;
  logic [CNT_W-1:0]  cfg_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [WIDTH:0]    in_sum;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  err_sum;
  logic [WIDTH:0]    err_max;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  smp_cnt;
`ifdef ERR_BIAS_EN
  logic signed [ACC_W-1:0] err_bias;

  modport master (
    output clear, start, cfg_n, in_valid, in_a, in_b, in_sum, res_ready,
    input  in_ready, res_valid, err_sum, err_max, err_cnt, smp_cnt, err_bias
  );
  modport slave (
    input  clear, start, cfg_n, in_valid, in_a, in_b, in_sum, res_ready,
    output in_ready, res_valid, err_sum, err_max, err_cnt, smp_cnt, err_bias
  );
`else
  modport master (
    output clear, start, cfg_n, in_valid, in_a, in_b, in_sum, res_ready,
    input  in_ready, res_valid, err_sum, err_max, err_cnt, smp_cnt
  );
  modport slave (
    input  clear, start, cfg_n, in_valid, in_a, in_b, in_sum, res_ready,
    output in_ready, res_valid, err_sum, err_max, err_cnt, smp_cnt
  );
`endif
endinterface

// File: rtl/approx_rc_err_monitor.sv
// Error-statistics monitor for an approximate WIDTH-bit adder over an N-sample window.
// Define ERR_BIAS_EN to add the saturating signed bias accumulator (err_bias).
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | accepting samples until cfg_n taken and the pipeline drains
// DONE  | results valid until res_ready, start or clear
module approx_rc_err_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = WIDTH + 1 + CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  approx_rc_err_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cfg_q;
  logic              in_ready_q;
  logic              res_valid_q;
  logic              s1_valid;
  logic [WIDTH:0]    s1_abs;
  logic [ACC_W-1:0]  err_sum_q;
  logic [WIDTH:0]    err_max_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  smp_cnt_q;

  logic              accept;
  logic [WIDTH:0]    exact;
  logic [WIDTH:0]    abs_d;
  logic [CNT_W-1:0]  smp_nxt;
  logic [ACC_W:0]    sum_ext;
  logic [ACC_W-1:0]  sum_sat;

  assign accept  = bus.in_valid & in_ready_q;
  assign exact   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign abs_d   = (bus.in_sum >= exact) ? (bus.in_sum - exact) : (exact - bus.in_sum);
  assign smp_nxt = accept ? (smp_cnt_q + CNT_W'(1)) : smp_cnt_q;
  assign sum_ext = {1'b0, err_sum_q} + {{(ACC_W - WIDTH){1'b0}}, s1_abs};
  // A carry out of the accumulator pins it at all-ones rather than wrapping.
  assign sum_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

`ifdef ERR_BIAS_EN
  logic signed [WIDTH+1:0] diff_d;
  logic signed [WIDTH+1:0] s1_diff;
  logic signed [ACC_W-1:0] err_bias_q;
  logic signed [ACC_W:0]   bias_ext;
  logic signed [ACC_W-1:0] bias_sat;

  assign diff_d   = $signed({1'b0, bus.in_sum}) - $signed({1'b0, exact});
  assign bias_ext = $signed({err_bias_q[ACC_W-1], err_bias_q}) + (ACC_W+1)'(s1_diff);
  // Overflow shows as disagreement between the two top bits of the widened sum.
  assign bias_sat = (bias_ext[ACC_W] == bias_ext[ACC_W-1]) ? bias_ext[ACC_W-1:0] :
                    bias_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  assign bus.err_bias = err_bias_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_diff    <= '0;
      err_bias_q <= '0;
    end else if (bus.clear) begin
      s1_diff    <= '0;
      err_bias_q <= '0;
    end else begin
      if (accept) s1_diff <= diff_d;
      if ((state == IDLE || state == DONE) && bus.start)
        err_bias_q <= '0;
      else if (state == RUN && s1_valid)
        err_bias_q <= bias_sat;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cfg_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      s1_valid    <= 1'b0;
      s1_abs      <= '0;
      err_sum_q   <= '0;
      err_max_q   <= '0;
      err_cnt_q   <= '0;
      smp_cnt_q   <= '0;
    end else if (bus.clear) begin
      state       <= IDLE;
      cfg_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      s1_valid    <= 1'b0;
      s1_abs      <= '0;
      err_sum_q   <= '0;
      err_max_q   <= '0;
      err_cnt_q   <= '0;
      smp_cnt_q   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_abs <= abs_d;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= RUN;
            cfg_q       <= bus.cfg_n;
            in_ready_q  <= (bus.cfg_n != '0);
            res_valid_q <= 1'b0;
            err_sum_q   <= '0;
            err_max_q   <= '0;
            err_cnt_q   <= '0;
            smp_cnt_q   <= '0;
          end else if (state == DONE && bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        RUN: begin
          smp_cnt_q  <= smp_nxt;
          in_ready_q <= (smp_nxt < cfg_q);
          if (s1_valid) begin
            err_sum_q <= sum_sat;
            if (s1_abs > err_max_q) err_max_q <= s1_abs;
            if (s1_abs != '0) err_cnt_q <= err_cnt_q + CNT_W'(1);
          end
          // Window closes only once the last accepted sample has left S2.
          if (smp_cnt_q == cfg_q && !s1_valid) begin
            state       <= DONE;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.err_sum   = err_sum_q;
  assign bus.err_max   = err_max_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.smp_cnt   = smp_cnt_q;
endmodule

// File: tb/tb_approx_rc_err_monitor.sv
// Self-checking bench for approx_rc_err_monitor: directed windows plus randomized
// windows scored against a per-sample arithmetic model of the error statistics.
module tb_approx_rc_err_monitor;
  localparam int WIDTH = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = WIDTH + 1 + CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  approx_rc_err_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();
  approx_rc_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  function automatic longint abs_err(input longint a, input longint b, input longint s);
    longint e;
    e = s - (a + b);
    return (e < 0) ? -e : e;
  endfunction

  task automatic do_start(input logic [CNT_W-1:0] n);
    bus.start = 1'b1;
    bus.cfg_n = n;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cfg_n = CNT_W'($urandom);
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH:0] s, input int gap, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_sum = s;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      waited++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_a = WIDTH'($urandom);
    bus.in_b = WIDTH'($urandom);
    bus.in_sum = (WIDTH+1)'($urandom);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready never seen, got %0b required 1", bus.in_ready);
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL done_timeout: res_valid got %0b required 1", bus.res_valid);
    end
  endtask

  task automatic ack();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b required 0", bus.in_ready); end
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %0b required 0", bus.res_valid); end
    n_cmp++; if (bus.err_sum !== '0 || bus.err_max !== '0) begin n_fail++; $display("FAIL reset_err got sum=%0d max=%0d required 0", bus.err_sum, bus.err_max); end
    n_cmp++; if (bus.err_cnt !== '0 || bus.smp_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got err_cnt=%0d smp_cnt=%0d required 0", bus.err_cnt, bus.smp_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_error();
    int w;
    do_start(1);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %0b required 1", bus.in_ready); end
    send(16'd0, 16'd0, 17'h08001, 0, w);
    n_cmp++; if (bus.smp_cnt !== 32'd1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL single_accept got smp=%0d rdy=%0b required 1/0", bus.smp_cnt, bus.in_ready); end
    n_cmp++; if (bus.err_sum !== '0) begin n_fail++; $display("FAIL single_latency got err_sum=%0d required 0", bus.err_sum); end
    @(negedge clk);
    n_cmp++; if (bus.err_sum !== 49'd32769) begin n_fail++; $display("FAIL single_s2 got err_sum=%0d required 32769", bus.err_sum); end
    wait_done();
    n_cmp++; if (bus.err_max !== 17'd32769 || bus.err_cnt !== 32'd1) begin n_fail++; $display("FAIL single_stats got max=%0d cnt=%0d required 32769/1", bus.err_max, bus.err_cnt); end
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.res_valid !== 1'b1 || bus.err_sum !== 49'd32769) begin n_fail++; $display("FAIL single_hold got rv=%0b sum=%0d required 1/32769", bus.res_valid, bus.err_sum); end
    ack();
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack got res_valid=%0b required 0", bus.res_valid); end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.err_sum !== 49'd32769 || bus.smp_cnt !== 32'd1) begin n_fail++; $display("FAIL idle_hold got sum=%0d smp=%0d required 32769/1", bus.err_sum, bus.smp_cnt); end
  endtask

  task automatic test_back_to_back();
    int w;
    do_start(2);
    send(16'd3, 16'd5, 17'd8, 0, w);
    send(16'd100, 16'd200, 17'd300, 0, w);
    n_cmp++; if (w !== 0) begin n_fail++; $display("FAIL b2b_stall got wait=%0d required 0", w); end
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.smp_cnt !== 32'd2) begin n_fail++; $display("FAIL b2b_ready got rdy=%0b smp=%0d required 0/2", bus.in_ready, bus.smp_cnt); end
    @(negedge clk);
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early got res_valid=%0b required 0", bus.res_valid); end
    @(negedge clk);
    n_cmp++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_done got res_valid=%0b required 1", bus.res_valid); end
    n_cmp++; if (bus.err_sum !== '0 || bus.err_cnt !== '0 || bus.err_max !== '0) begin n_fail++; $display("FAIL b2b_stats got sum=%0d cnt=%0d max=%0d required 0", bus.err_sum, bus.err_cnt, bus.err_max); end
    ack();
  endtask

  task automatic test_gaps();
    int w;
    do_start(3);
    send(16'd0, 16'd0, 17'd4, 2, w);
    send(16'd0, 16'd0, 17'h1FFFF, 3, w);
    send(16'd10, 16'd5, 17'd13, 1, w);
    wait_done();
    n_cmp++; if (bus.err_sum !== 49'd131077) begin n_fail++; $display("FAIL gaps_sum got %0d required 131077", bus.err_sum); end
    n_cmp++; if (bus.err_max !== 17'h1FFFF) begin n_fail++; $display("FAIL gaps_max got %0h required 1ffff", bus.err_max); end
    n_cmp++; if (bus.err_cnt !== 32'd3 || bus.smp_cnt !== 32'd3) begin n_fail++; $display("FAIL gaps_cnt got cnt=%0d smp=%0d required 3/3", bus.err_cnt, bus.smp_cnt); end
    ack();
  endtask

  task automatic test_cfg_zero();
    bus.in_valid = 1'b1;
    do_start(0);
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL zero_run got rdy=%0b rv=%0b required 0/0", bus.in_ready, bus.res_valid); end
    n_cmp++; if (bus.err_sum !== '0 || bus.err_max !== '0) begin n_fail++; $display("FAIL zero_clr got sum=%0d max=%0d required 0", bus.err_sum, bus.err_max); end
    @(negedge clk);
    n_cmp++; if (bus.res_valid !== 1'b1 || bus.smp_cnt !== '0 || bus.err_cnt !== '0) begin n_fail++; $display("FAIL zero_done got rv=%0b smp=%0d cnt=%0d required 1/0/0", bus.res_valid, bus.smp_cnt, bus.err_cnt); end
    bus.in_valid = 1'b0;
    ack();
  endtask

  task automatic test_clear();
    int w;
    do_start(5);
    send(16'd1, 16'd1, 17'd9, 0, w);
    send(16'd1, 16'd1, 17'd0, 0, w);
    bus.in_valid = 1'b1;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.smp_cnt !== '0) begin n_fail++; $display("FAIL clear_run got rdy=%0b smp=%0d required 0/0", bus.in_ready, bus.smp_cnt); end
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.err_sum !== '0 || bus.err_cnt !== '0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL clear_stats got sum=%0d cnt=%0d rv=%0b required 0", bus.err_sum, bus.err_cnt, bus.res_valid); end
    do_start(1);
    send(16'd2, 16'd2, 17'd1, 0, w);
    wait_done();
    bus.clear = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.start = 1'b0;
    n_cmp++; if (bus.res_valid !== 1'b0 || bus.err_sum !== '0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_done got rv=%0b sum=%0d rdy=%0b required 0", bus.res_valid, bus.err_sum, bus.in_ready); end
  endtask

  task automatic test_random();
    int w;
    int n;
    longint esum, emax, ecnt, e;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0] s;
    longint ex;
    for (int win = 0; win < 8; win++) begin
      n = $urandom_range(1, 24);
      esum = 0; emax = 0; ecnt = 0;
      do_start(CNT_W'(n));
      for (int k = 0; k < n; k++) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        ex = longint'(a) + longint'(b);
        case ($urandom % 4)
          0: s = (WIDTH+1)'(ex);
          1: s = (WIDTH+1)'((ex >= 8) ? ex - $urandom_range(1, 7) : ex + $urandom_range(1, 7));
          2: s = (WIDTH+1)'($urandom);
          default: s = (WIDTH+1)'(ex ^ (longint'(1) << $urandom_range(0, WIDTH)));
        endcase
        e = abs_err(longint'(a), longint'(b), longint'(s));
        esum += e;
        if (e > emax) emax = e;
        if (e != 0) ecnt++;
        send(a, b, s, (($urandom % 3) == 0) ? $urandom_range(1, 3) : 0, w);
      end
      wait_done();
      n_cmp++; if (bus.err_sum !== ACC_W'(esum)) begin n_fail++; $display("FAIL rand_sum win%0d got %0d required %0d", win, bus.err_sum, esum); end
      n_cmp++; if (bus.err_max !== (WIDTH+1)'(emax)) begin n_fail++; $display("FAIL rand_max win%0d got %0d required %0d", win, bus.err_max, emax); end
      n_cmp++; if (bus.err_cnt !== CNT_W'(ecnt)) begin n_fail++; $display("FAIL rand_cnt win%0d got %0d required %0d", win, bus.err_cnt, ecnt); end
      n_cmp++; if (bus.smp_cnt !== CNT_W'(n)) begin n_fail++; $display("FAIL rand_smp win%0d got %0d required %0d", win, bus.smp_cnt, n); end
      if ($urandom % 2 == 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ack();
      end
    end
    if (bus.res_valid) ack();
  endtask

`ifdef ERR_BIAS_EN
  task automatic test_bias();
    int w;
    logic signed [ACC_W-1:0] exp_b;
    exp_b = -2;
    do_start(2);
    send(16'd3, 16'd5, 17'd10, 0, w);
    send(16'd3, 16'd5, 17'd4, 0, w);
    wait_done();
    n_cmp++; if (bus.err_bias !== exp_b) begin n_fail++; $display("FAIL bias got %0d required -2", bus.err_bias); end
    n_cmp++; if (bus.err_sum !== 49'd6) begin n_fail++; $display("FAIL bias_sum got %0d required 6", bus.err_sum); end
    ack();
  endtask
`endif

  task automatic test_reset_mid_run();
    int w;
    do_start(10);
    send(16'd0, 16'd0, 17'd5, 0, w);
    send(16'd0, 16'd0, 17'd6, 0, w);
    send(16'd0, 16'd0, 17'd7, 0, w);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.err_sum !== 49'd18) begin n_fail++; $display("FAIL midrun_pre got sum=%0d required 18", bus.err_sum); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_flags got rdy=%0b rv=%0b required 0/0", bus.in_ready, bus.res_valid); end
    n_cmp++; if (bus.err_sum !== '0 || bus.smp_cnt !== '0 || bus.err_cnt !== '0 || bus.err_max !== '0) begin n_fail++; $display("FAIL midrun_stats got sum=%0d smp=%0d cnt=%0d max=%0d required 0", bus.err_sum, bus.smp_cnt, bus.err_cnt, bus.err_max); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.smp_cnt !== '0) begin n_fail++; $display("FAIL midrun_idle got rdy=%0b smp=%0d required 0/0", bus.in_ready, bus.smp_cnt); end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.clear = 1'b0;
    bus.start = 1'b0;
    bus.cfg_n = '0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_sum = '0;
    bus.res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_error();
    test_back_to_back();
    test_gaps();
    test_cfg_zero();
    test_clear();
    test_random();
`ifdef ERR_BIAS_EN
    test_bias();
`endif
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
